// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master and its adder peripheral.
package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Adder peripheral register map
  localparam logic [7:0] ADD2_REG_A = 8'h00;
  localparam logic [7:0] ADD2_REG_B = 8'h04;
  localparam logic [7:0] ADD2_REG_X = 8'h08;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB3 signal bundle for apb_cmd_master.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master_timeout_ctr.sv
// ACCESS-phase wait counter; expired_c flags the last permitted cycle without PREADY.
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (TIMEOUT != 0)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // TIMEOUT of zero never expires
  assign expired_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 master: valid/ready command in, SETUP/ACCESS on APB,
// valid/ready response out with PSLVERR and PREADY-timeout reporting.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_cmd_master_if.master  bus
);

  state_e state_q, state_d;
  logic   cap_cmd, cap_rsp, abort;
  logic   ctr_clr, ctr_en, expired_c;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (PCLK),
    .rst       (PRESET),
    .clr       (ctr_clr),
    .en        (ctr_en),
    .expired_c (expired_c)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes; PREADY wins over a same-cycle expiry
  always_comb begin
    state_d = state_q;
    cap_cmd = 1'b0;
    cap_rsp = 1'b0;
    abort   = 1'b0;
    ctr_clr = (state_q == ST_SETUP);
    ctr_en  = (state_q == ST_ACCESS) && !bus.PREADY;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cap_cmd = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          cap_rsp = 1'b1;
          state_d = ST_RESP;
        end else if (expired_c) begin
          abort   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs registered from the next state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end else begin
      bus.cmd_ready <= (state_d == ST_IDLE);
      bus.busy      <= (state_d != ST_IDLE);
      bus.PSEL      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      bus.PENABLE   <= (state_d == ST_ACCESS);
      bus.rsp_valid <= (state_d == ST_RESP);
    end
  end

  // Request fields hold until the next accept; response fields hold through RESP
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= ADDR_W'(0);
      bus.PWDATA      <= DATA_W'(0);
      bus.rsp_rdata   <= DATA_W'(0);
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (cap_cmd) begin
        bus.PWRITE <= bus.cmd_write;
        bus.PADDR  <= bus.cmd_addr;
        bus.PWDATA <= bus.cmd_wdata;
      end
      if (cap_rsp) begin
        bus.rsp_rdata   <= bus.PWRITE ? DATA_W'(0) : bus.PRDATA;
        bus.rsp_err     <= bus.PSLVERR;
        bus.rsp_timeout <= 1'b0;
      end else if (abort) begin
        bus.rsp_rdata   <= DATA_W'(0);
        bus.rsp_err     <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
